// File: rtl/regmap_trigger_multi.sv
// regmap_trigger_multi: NUM_CH shadow/active trigger config banks with atomic commit, write lock, sticky status, saturating hit counters, masked irq and registered reads
module regmap_trigger_multi #(
  parameter int NUM_CH = 4
) (
  input  logic                clk,
  input  logic                rst_n_sync,
  input  logic [7:0]          address,
  input  logic                trigger_write_enable,
  input  logic [7:0]          write_data_in,
  input  logic                trigger_read_enable,
  output logic [7:0]          trigger_read_data,
  output logic                trigger_read_valid,
  input  logic [NUM_CH-1:0]   trigger_event,
  output logic [NUM_CH-1:0]   cfg_positive,
  output logic [3*NUM_CH-1:0] cfg_type,
  output logic [5*NUM_CH-1:0] cfg_stage1_count,
  output logic [3*NUM_CH-1:0] cfg_time_base,
  output logic [8*NUM_CH-1:0] cfg_count1,
  output logic [8*NUM_CH-1:0] cfg_count2,
  output logic [NUM_CH-1:0]   cfg_longer_no_edge,
  output logic [NUM_CH-1:0]   cfg_trig_dur_sel,
  output logic [NUM_CH-1:0]   cfg_enable,
  output logic                cfg_update,
  output logic                irq
);
  logic [NUM_CH-1:0] sh_positive, sh_longer_no_edge, sh_trig_dur_sel, sh_enable;
  logic [3*NUM_CH-1:0] sh_type, sh_time_base;
  logic [5*NUM_CH-1:0] sh_stage1_count;
  logic [8*NUM_CH-1:0] sh_count1, sh_count2;
  logic [7:0] hit_count [NUM_CH];
  logic [NUM_CH-1:0] status, irq_mask, hit, w1c;
  logic locked, commit_pending, bank_wr;
  logic [7:0] rd_mux;
  assign bank_wr = trigger_write_enable && !locked && address < 8'hF0;
  assign w1c = (trigger_write_enable && address == 8'hF1) ? write_data_in[NUM_CH-1:0] : '0;
  assign hit = trigger_event & cfg_enable;
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (address[7:4] == 4'(c))
        case (address[3:0])
          4'd0: rd_mux = 8'(sh_positive[c]);
          4'd1: rd_mux = 8'(sh_type[3*c +: 3]);
          4'd2: rd_mux = 8'(sh_stage1_count[5*c +: 5]);
          4'd3: rd_mux = 8'(sh_time_base[3*c +: 3]);
          4'd4: rd_mux = sh_count1[8*c +: 8];
          4'd5: rd_mux = sh_count2[8*c +: 8];
          4'd6: rd_mux = 8'(sh_longer_no_edge[c]);
          4'd7: rd_mux = 8'(sh_trig_dur_sel[c]);
          4'd8: rd_mux = 8'(sh_enable[c]);
          4'd9: rd_mux = hit_count[c];
          default: ;
        endcase
    case (address)
      8'hF1: rd_mux = 8'(status);
      8'hF2: rd_mux = 8'(locked);
      8'hF3: rd_mux = {4'h2, 4'(NUM_CH)};
      8'hF4: rd_mux = 8'(irq_mask);
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n_sync)
    if (!rst_n_sync) begin
      sh_positive <= '0;
      sh_type <= '0;
      sh_stage1_count <= '0;
      sh_time_base <= '0;
      sh_count1 <= '0;
      sh_count2 <= '0;
      sh_longer_no_edge <= '0;
      sh_trig_dur_sel <= '0;
      sh_enable <= '0;
    end else if (bank_wr)
      for (int c = 0; c < NUM_CH; c++)
        if (address[7:4] == 4'(c))
          case (address[3:0])
            4'd0: sh_positive[c] <= write_data_in[0];
            4'd1: sh_type[3*c +: 3] <= write_data_in[2:0];
            4'd2: sh_stage1_count[5*c +: 5] <= write_data_in[4:0];
            4'd3: sh_time_base[3*c +: 3] <= write_data_in[2:0];
            4'd4: sh_count1[8*c +: 8] <= write_data_in;
            4'd5: sh_count2[8*c +: 8] <= write_data_in;
            4'd6: sh_longer_no_edge[c] <= write_data_in[0];
            4'd7: sh_trig_dur_sel[c] <= write_data_in[0];
            4'd8: sh_enable[c] <= write_data_in[0];
            default: ;
          endcase
  always_ff @(posedge clk or negedge rst_n_sync)
    if (!rst_n_sync) begin
      commit_pending <= 1'b0;
      cfg_update <= 1'b0;
      cfg_positive <= '0;
      cfg_type <= '0;
      cfg_stage1_count <= '0;
      cfg_time_base <= '0;
      cfg_count1 <= '0;
      cfg_count2 <= '0;
      cfg_longer_no_edge <= '0;
      cfg_trig_dur_sel <= '0;
      cfg_enable <= '0;
    end else begin
      commit_pending <= trigger_write_enable && !locked && address == 8'hF0 && write_data_in[0];
      cfg_update <= commit_pending;
      if (commit_pending) begin
        cfg_positive <= sh_positive;
        cfg_type <= sh_type;
        cfg_stage1_count <= sh_stage1_count;
        cfg_time_base <= sh_time_base;
        cfg_count1 <= sh_count1;
        cfg_count2 <= sh_count2;
        cfg_longer_no_edge <= sh_longer_no_edge;
        cfg_trig_dur_sel <= sh_trig_dur_sel;
        cfg_enable <= sh_enable;
      end
    end
  always_ff @(posedge clk or negedge rst_n_sync)
    if (!rst_n_sync) begin
      status <= '0;
      irq_mask <= '0;
      locked <= 1'b0;
      irq <= 1'b0;
      trigger_read_data <= '0;
      trigger_read_valid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) hit_count[c] <= '0;
    end else begin
      status <= (status & ~w1c) | hit;
      for (int c = 0; c < NUM_CH; c++)
        hit_count[c] <= hit[c] ? (w1c[c] ? 8'd1 : hit_count[c] + {7'd0, hit_count[c] != 8'hFF}) :
                        w1c[c] ? 8'd0 : hit_count[c];
      if (trigger_write_enable && address == 8'hF2) locked <= write_data_in != 8'hA5;
      if (trigger_write_enable && address == 8'hF4) irq_mask <= write_data_in[NUM_CH-1:0];
      irq <= |(status & irq_mask);
      trigger_read_valid <= trigger_read_enable;
      trigger_read_data <= trigger_read_enable ? rd_mux : '0;
    end
endmodule

// File: doc/regmap_trigger_multi.md
# regmap_trigger_multi

Multi-channel, parametrised configuration and status register map for the UART-controlled trigger engine. It holds NUM_CH banks of trigger configuration in shadow registers, and applies them atomically to the active outputs on a commit command. It also provides a write lock, per-channel sticky status with saturating hit counters, a masked interrupt, and registered read data. It sits between the UART command decoder and the NUM_CH trigger cores.

## Interface
- NUM_CH, 4, number of trigger channels; legal range 1..8
- clk  input  1  system clock
- rst_n_sync  input  1  reset, asynchronous, active-low; clock clk
- address  input  8  register address
- trigger_write_enable  input  1  write strobe, one cycle per write
- write_data_in  input  8  write data
- trigger_read_enable  input  1  read strobe, one cycle per read
- trigger_read_data  output  8  registered read data; 0 when trigger_read_valid is low
- trigger_read_valid  output  1  one-cycle pulse qualifying trigger_read_data
- trigger_event  input  NUM_CH  per-channel trigger-fired pulse from trigger cores
- cfg_positive  output  NUM_CH  active config, 1 bit per channel
- cfg_type  output  3*NUM_CH  active config; channel c is at [3c+2:3c]
- cfg_stage1_count  output  5*NUM_CH  active config
- cfg_time_base  output  3*NUM_CH  active config
- cfg_count1, cfg_count2  output  8*NUM_CH  active config
- cfg_longer_no_edge, cfg_trig_dur_sel, cfg_enable  output  NUM_CH  active config
- cfg_update  output  1  one-cycle pulse when the active config is reloaded
- irq  output  1  OR of (status & irq_mask), registered

## Operation
- Channel bank c is at address 16*c + offset, for c < NUM_CH.
  - Offsets 0..8 are the shadow fields, in this order: positive[0], type[2:0], stage1_count[4:0], time_base[2:0], count1[7:0], count2[7:0], longer_no_edge[0], trig_dur_sel[0], enable[0].
  - Unused upper bits are written as don't-care and read as 0.
  - Offset 9 is HIT_COUNT (read-only, 8 bits, saturates at 255).
  - Offsets 10..15 read 0; writes to them are ignored.
- Banks with c >= NUM_CH (below 0xF0): reads return 0, writes are ignored.
- Global registers:
  - 0xF0 COMMIT: a write with bit0=1 requests a commit. Reads 0.
  - 0xF1 STATUS: sticky per-channel fired bits; bits >= NUM_CH read 0. Write-1-to-clear. Clearing bit c also clears HIT_COUNT[c].
  - 0xF2 LOCK: writing 0xA5 unlocks; writing any other value locks. Reads 1 when locked, 0 when unlocked.
  - 0xF3 ID: read-only {4'h2, NUM_CH[3:0]}.
  - 0xF4 IRQ_MASK: read/write; only bits [NUM_CH-1:0] are stored.
  - 0xF5..0xFF read 0.
- While locked, bank writes and COMMIT are ignored. STATUS, LOCK and IRQ_MASK remain writable.
- A commit copies all shadow fields of every channel into the active cfg_* outputs simultaneously.
- A trigger_event[c] pulse is counted only when active cfg_enable[c]=1. It sets STATUS[c] and increments HIT_COUNT[c], holding at 255 once saturated.
- Simultaneous events:
  - W1C of STATUS[c] and an event on c in the same cycle: the event wins. STATUS[c] stays 1 and HIT_COUNT[c] loads 1.
  - Read and write to the same address in the same cycle: the read returns the pre-write value.
  - Bank read: returns the shadow value, not the active value.
- Reset values: all shadow and active fields 0; STATUS 0; HIT_COUNT 0; IRQ_MASK 0; unlocked; cfg_update 0; irq 0; trigger_read_data 0; trigger_read_valid 0.
- Reset asserted mid-operation (including during a commit) discards any pending commit; all outputs return to their reset values.

## Timing
- Write sampled at clock edge N: the shadow, STATUS, LOCK or IRQ_MASK register holds the new value after edge N.
- Commit sampled at edge N: pending flag set at N. Active cfg_* outputs change at edge N+1. cfg_update is high between edges N+1 and N+2.
- Read sampled at edge N: trigger_read_data and trigger_read_valid are valid between edges N and N+1. Back-to-back reads produce back-to-back valid pulses.
- Event sampled at edge N: STATUS and HIT_COUNT update at N; irq updates at N+1.
- Active config does not change between commits, regardless of shadow writes.

## Test plan
- Reset, then read 0xF3 with NUM_CH=4 -> data 0x24, valid one cycle later; read 0x04 -> 0x00; all cfg_* outputs 0, irq 0.
- Write 0x14=0x3C (ch1 count1), read it back -> 0x3C; cfg_count1[15:8] stays 0. Write 0xF0=0x01 -> cfg_count1[15:8]=0x3C two cycles after the commit strobe; cfg_update pulses for exactly 1 cycle.
- Write 0xF2=0x00 (lock), then write 0x08=0x01 and 0xF0=0x01 -> shadow reads 0 and cfg_enable is unchanged. Write 0xF2=0xA5, then retry both -> cfg_enable[0]=1.
- Commit enable on ch0, set IRQ_MASK=0x01, apply 300 trigger_event[0] pulses -> HIT_COUNT (0x09) reads 255, STATUS reads 0x01, irq=1. Write 0xF1=0x01 -> STATUS 0, HIT_COUNT 0, irq 0.
- Apply W1C of STATUS bit 0 in the same cycle as trigger_event[0] -> STATUS bit0=1, HIT_COUNT=1. Event on ch2 while cfg_enable[2]=0 -> no change.
- Write 0x50 (bank 5, with NUM_CH=4) and 0xF7 -> no register changes; reads return 0 with valid asserted. Assert rst_n_sync the cycle after a commit strobe -> cfg_update never pulses and all outputs are 0.
